// File: rtl/nor_pkg.sv
// rtl/nor_pkg.sv - shared commands, status bits and state encodings for the NOR word-program engine
package nor_pkg;

    // Intel/Micron StrataFlash command codes (low byte carries the opcode)
    localparam logic [15:0] CMD_PROGRAM     = 16'h0040;
    localparam logic [15:0] CMD_CLR_STATUS  = 16'h0050;
    localparam logic [15:0] CMD_READ_ARRAY  = 16'h00FF;
    localparam logic [15:0] CMD_READ_STATUS = 16'h0070;

    // Status register bit positions
    localparam int SR_READY   = 7;
    localparam int SR_PGM_ERR = 4;
    localparam int SR_VPP_ERR = 3;
    localparam int SR_LOCK    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_CMD,
        S_W_DAT,
        S_POLL,
        S_W_CLR,
        S_W_RA,
        S_VERIFY,
        S_FIN
    } nor_state_e;

    typedef enum logic [2:0] {
        BP_IDLE,
        BP_SETUP,
        BP_LOW,
        BP_HOLD,
        BP_RASSERT,
        BP_RREL
    } bus_phase_e;

    function automatic logic sr_has_error(input logic [7:0] sr);
        return sr[SR_PGM_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK];
    endfunction

endpackage

// File: rtl/nor_bus_cycle.sv
// rtl/nor_bus_cycle.sv - single NOR bus write/read primitive with registered strobes
module nor_bus_cycle
    import nor_pkg::*;
#(
    parameter int WE_LOW_CYC  = 3,
    parameter int RD_WAIT_CYC = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start_i,
    input  logic        rd_nwr_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] data_i,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        ce_n_o,
    output logic        we_n_o,
    output logic        oe_n_o,
    output logic        data_oe_o,
    output logic [15:0] data_o,
    output logic [23:0] addr_o
);

    bus_phase_e  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ce_n_q, we_n_q, oe_n_q, drive_q;
    logic [23:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic        accept, sample;

    // The last cycle of a primitive reports done, so the sequencer can chain the next one without a gap
    assign done_o = (phase_q == BP_HOLD) || (phase_q == BP_RREL);
    assign accept = start_i && ((phase_q == BP_IDLE) || done_o);
    assign sample = (phase_q == BP_RASSERT) && (cnt_q == 8'(RD_WAIT_CYC - 1));

    // Phase sequencing: SETUP -> LOW x WE_LOW_CYC -> HOLD, or RASSERT x RD_WAIT_CYC -> RREL
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (phase_q)
            BP_SETUP: begin
                phase_d = BP_LOW;
                cnt_d   = 8'd0;
            end
            BP_LOW: begin
                if (cnt_q == 8'(WE_LOW_CYC - 1)) phase_d = BP_HOLD;
                else                             cnt_d   = cnt_q + 8'd1;
            end
            BP_RASSERT: begin
                if (sample) phase_d = BP_RREL;
                else        cnt_d   = cnt_q + 8'd1;
            end
            BP_HOLD, BP_RREL: phase_d = BP_IDLE;
            default: ;
        endcase
        if (accept) begin
            phase_d = rd_nwr_i ? BP_RASSERT : BP_SETUP;
            cnt_d   = 8'd0;
        end
    end

    // Strobes and data enable are registered from the next phase so they are glitch-free and phase-aligned
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q <= BP_IDLE;
            cnt_q   <= 8'd0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drive_q <= 1'b0;
            addr_q  <= 24'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= !((phase_d == BP_LOW) || (phase_d == BP_RASSERT));
            we_n_q  <= (phase_d != BP_LOW);
            oe_n_q  <= (phase_d != BP_RASSERT);
            drive_q <= (phase_d == BP_SETUP) || (phase_d == BP_LOW) || (phase_d == BP_HOLD);
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (sample) rdata_q <= data_i;
        end
    end

    assign rdata_o   = rdata_q;
    assign ce_n_o    = ce_n_q;
    assign we_n_o    = we_n_q;
    assign oe_n_o    = oe_n_q;
    assign data_oe_o = drive_q;
    assign data_o    = wdata_q;
    assign addr_o    = addr_q;

endmodule

// File: rtl/nor_word_program.sv
// rtl/nor_word_program.sv - NOR flash word-program sequencer (optional read-back: NOR_PGM_VERIFY_EN)
module nor_word_program
    import nor_pkg::*;
#(
    parameter int WE_LOW_CYC  = 3,
    parameter int RD_WAIT_CYC = 6,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [23:0] WADDR,
    input  logic [15:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  STATUS,
    output logic        CE,
    output logic        WE,
    output logic        OE,
    output logic [23:0] ADDR,
    inout  wire  [15:0] DATA
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    nor_state_e  state_q, state_d;
    logic [23:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;

    logic        bus_start, bus_rd, bus_done, bus_oe;
    logic [23:0] bus_addr;
    logic [15:0] bus_wdata, bus_rdata, bus_dout;
    logic [7:0]  sr;

    assign sr = bus_rdata[7:0];

    nor_bus_cycle #(
        .WE_LOW_CYC (WE_LOW_CYC),
        .RD_WAIT_CYC(RD_WAIT_CYC)
    ) u_bus (
        .CLK      (CLK),
        .RESET    (RESET),
        .start_i  (bus_start),
        .rd_nwr_i (bus_rd),
        .addr_i   (bus_addr),
        .wdata_i  (bus_wdata),
        .data_i   (DATA),
        .done_o   (bus_done),
        .rdata_o  (bus_rdata),
        .ce_n_o   (CE),
        .we_n_o   (WE),
        .oe_n_o   (OE),
        .data_oe_o(bus_oe),
        .data_o   (bus_dout),
        .addr_o   (ADDR)
    );

    assign DATA = bus_oe ? bus_dout : 16'hzzzz;

`ifndef NOR_PGM_VERIFY_EN
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus_rdata[15:8];
`endif

    // Command sequencing; each bus primitive is launched in the done cycle of the previous one
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        status_d   = status_q;
        err_d      = err_q;
        bus_start  = 1'b0;
        bus_rd     = 1'b0;
        bus_addr   = waddr_q;
        bus_wdata  = CMD_READ_ARRAY;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    waddr_d    = WADDR;
                    wdata_d    = WDATA;
                    poll_cnt_d = 16'd0;
                    status_d   = 8'h00;
                    err_d      = 1'b0;
                    bus_start  = 1'b1;
                    bus_addr   = WADDR;
                    bus_wdata  = CMD_PROGRAM;
                    state_d    = S_W_CMD;
                end
            end
            S_W_CMD: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    bus_wdata = wdata_q;
                    state_d   = S_W_DAT;
                end
            end
            S_W_DAT: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    bus_rd    = 1'b1;
                    state_d   = S_POLL;
                end
            end
            S_POLL: begin
                if (bus_done) begin
                    status_d  = {sr[7:1], 1'b0};
                    bus_start = 1'b1;
                    if (sr[SR_READY]) begin
                        if (sr_has_error(sr)) begin
                            err_d     = 1'b1;
                            bus_wdata = CMD_CLR_STATUS;
                            state_d   = S_W_CLR;
                        end else begin
                            bus_wdata = CMD_READ_ARRAY;
                            state_d   = S_W_RA;
                        end
                    end else begin
                        poll_cnt_d = (poll_cnt_q < TIMEOUT_LIM) ? poll_cnt_q + 16'd1 : poll_cnt_q;
                        if (poll_cnt_d == TIMEOUT_LIM) begin
                            status_d[0] = 1'b1;
                            err_d       = 1'b1;
                            bus_wdata   = CMD_CLR_STATUS;
                            state_d     = S_W_CLR;
                        end else begin
                            bus_rd = 1'b1;
                        end
                    end
                end
            end
            S_W_CLR: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    bus_wdata = CMD_READ_ARRAY;
                    state_d   = S_W_RA;
                end
            end
            S_W_RA: begin
                if (bus_done) begin
`ifdef NOR_PGM_VERIFY_EN
                    if (!err_q) begin
                        bus_start = 1'b1;
                        bus_rd    = 1'b1;
                        state_d   = S_VERIFY;
                    end else begin
                        state_d = S_FIN;
                    end
`else
                    state_d = S_FIN;
`endif
                end
            end
`ifdef NOR_PGM_VERIFY_EN
            S_VERIFY: begin
                if (bus_done) begin
                    if (bus_rdata != wdata_q) begin
                        err_d       = 1'b1;
                        status_d[0] = 1'b1;
                    end
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and per-request context
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            waddr_q    <= 24'd0;
            wdata_q    <= 16'd0;
            poll_cnt_q <= 16'd0;
            status_q   <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            status_q   <= status_d;
            err_q      <= err_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE) && (state_q != S_FIN);
    assign DONE   = (state_q == S_FIN);
    assign ERR    = err_q;
    assign STATUS = status_q;

endmodule
